alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 176 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- registered ALU execute stage with valid/ready handshake on
// both sides. Decodes a main-decoder alu_op plus R-type funct into a 4-bit
// control code, computes add/sub/and/or/slt/nor in a single cycle and holds
// the result until the consumer takes it.
//
// Optional feature: define ALU_EXEC_SHIFT_EN to add iterative sll/srl
// (funct 000000 / 000010, amount b[SHW-1:0], one bit per cycle).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake (alu_op, funct, a, b)
//   out_valid/out_ready result handshake (result, zero, alu_ctl, illegal)
//   zero              result == 0, derived from the registered result
//   alu_ctl           control code of the completed operation
//   illegal           completed operation had an undecodable alu_op/funct
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       alu_ctl,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  typedef enum logic [3:0] {
    CTL_AND = 4'b0000,
    CTL_OR  = 4'b0001,
    CTL_ADD = 4'b0010,
    CTL_SUB = 4'b0110,
    CTL_SLT = 4'b0111,
    CTL_SLL = 4'b1000,
    CTL_SRL = 4'b1001,
    CTL_NOR = 4'b1100,
    CTL_ILL = 4'b1111
  } ctl_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  ctl_e             ctl_q, ctl_d;
  logic             illegal_q, illegal_d;
  // Low while in reset, high from the first clock edge after release, so
  // in_ready stays deasserted until the unit has seen a clock.
  logic             init_q;

  ctl_e             dec_ctl;
  logic [WIDTH-1:0] op_res;
  logic             accept;

`ifdef ALU_EXEC_SHIFT_EN
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [SHW-1:0]   amt;
  assign amt = b[SHW-1:0];
`endif

  always_comb begin
    dec_ctl = CTL_ILL;
    case (alu_op)
      2'b00: dec_ctl = CTL_ADD;
      2'b01: dec_ctl = CTL_SUB;
      2'b10: begin
        case (funct)
          6'b100000: dec_ctl = CTL_ADD;
          6'b100010: dec_ctl = CTL_SUB;
          6'b100100: dec_ctl = CTL_AND;
          6'b100101: dec_ctl = CTL_OR;
          6'b101010: dec_ctl = CTL_SLT;
          6'b100111: dec_ctl = CTL_NOR;
`ifdef ALU_EXEC_SHIFT_EN
          6'b000000: dec_ctl = CTL_SLL;
          6'b000010: dec_ctl = CTL_SRL;
`endif
          default:   dec_ctl = CTL_ILL;
        endcase
      end
      default: dec_ctl = CTL_ILL;
    endcase
  end

  always_comb begin
    op_res = '0;
    case (dec_ctl)
      CTL_ADD: op_res = a + b;
      CTL_SUB: op_res = a - b;
      CTL_AND: op_res = a & b;
      CTL_OR:  op_res = a | b;
      CTL_NOR: op_res = ~(a | b);
      CTL_SLT: op_res[0] = $signed(a) < $signed(b);
`ifdef ALU_EXEC_SHIFT_EN
      // Shifts load the operand; BUSY then shifts it one bit per cycle.
      CTL_SLL, CTL_SRL: op_res = a;
`endif
      default: op_res = '0;
    endcase
  end

  assign in_ready = init_q & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    ctl_d     = ctl_q;
    illegal_d = illegal_q;
`ifdef ALU_EXEC_SHIFT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      BUSY: begin
`ifdef ALU_EXEC_SHIFT_EN
        result_d = (ctl_q == CTL_SLL) ? (result_q << 1) : (result_q >> 1);
        cnt_d    = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = HOLD;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        if ((state_q == HOLD) && out_ready) state_d = IDLE;
        if (accept) begin
          result_d  = op_res;
          ctl_d     = dec_ctl;
          illegal_d = (dec_ctl == CTL_ILL);
          state_d   = HOLD;
`ifdef ALU_EXEC_SHIFT_EN
          if (((dec_ctl == CTL_SLL) || (dec_ctl == CTL_SRL)) && (amt != '0)) begin
            state_d = BUSY;
            cnt_d   = amt;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      ctl_q     <= CTL_AND;
      illegal_q <= 1'b0;
      init_q    <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      ctl_q     <= ctl_d;
      illegal_q <= illegal_d;
      init_q    <= 1'b1;
`ifdef ALU_EXEC_SHIFT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign alu_ctl   = ctl_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=32). A transaction-level
// reference model tracks whether a result is pending, how many shift cycles
// remain, and the expected output fields; every cycle the DUT handshake and
// output fields are compared against it.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   alu_op = '0;
  logic [5:0]   funct = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic [3:0]   alu_ctl;
  logic         illegal;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .alu_ctl(alu_ctl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit           m_valid;
  int unsigned  m_busy;
  logic [W-1:0] m_res, m_pend;
  logic [3:0]   m_ctl, m_pctl;

  function automatic void ref_op(input logic [1:0] op, input logic [5:0] f,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [3:0] ctl, output logic [W-1:0] r,
                                 output int unsigned n);
    n = 0; ctl = 4'hF; r = '0;
    if (op == 2'b00) begin ctl = 4'h2; r = x + y; end
    else if (op == 2'b01) begin ctl = 4'h6; r = x - y; end
    else if (op == 2'b10) begin
      case (f)
        6'h20: begin ctl = 4'h2; r = x + y; end
        6'h22: begin ctl = 4'h6; r = x - y; end
        6'h24: begin ctl = 4'h0; r = x & y; end
        6'h25: begin ctl = 4'h1; r = x | y; end
        6'h2A: begin ctl = 4'h7; r = ($signed(x) < $signed(y)) ? 1 : 0; end
        6'h27: begin ctl = 4'hC; r = ~(x | y); end
`ifdef ALU_EXEC_SHIFT_EN
        6'h00: begin ctl = 4'h8; n = y[4:0]; r = x << n; end
        6'h02: begin ctl = 4'h9; n = y[4:0]; r = x >> n; end
`endif
        default: begin ctl = 4'hF; r = '0; end
      endcase
    end
  endfunction

  // Drive one cycle of inputs, compare outputs against the model, advance the
  // model across the coming clock edge. Returns at posedge + 1.
  task automatic cycle(input bit iv, input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] x, input logic [W-1:0] y, input bit ordy);
    bit exp_rdy;
    logic [3:0] c;
    logic [W-1:0] r;
    int unsigned n;
    in_valid = iv; alu_op = op; funct = f; a = x; b = y; out_ready = ordy;
    #2;
    exp_rdy = (m_busy == 0) && (!m_valid || ordy);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("result", result, m_res);
      check("zero", zero, m_res == 0);
      check("alu_ctl", alu_ctl, m_ctl);
      check("illegal", illegal, m_ctl == 4'hF);
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_valid = 1; m_res = m_pend; m_ctl = m_pctl; end
    end else begin
      if (m_valid && ordy) m_valid = 0;
      if (iv && exp_rdy) begin
        ref_op(op, f, x, y, c, r, n);
        if (n > 0) begin m_busy = n; m_pend = r; m_pctl = c; end
        else begin m_valid = 1; m_res = r; m_ctl = c; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) cycle(1'b0, 2'b00, 6'h00, '0, '0, 1'b1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1'b1);
    check("rst_alu_ctl", alu_ctl, 4'h0);
    check("rst_illegal", illegal, 1'b0);
    m_valid = 0; m_busy = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_pre_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    check("rel_in_ready_post_edge", in_ready, 1'b1);
  endtask

  logic [5:0] fl [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h02};

  initial begin
    #1;
    apply_reset();

    // sub 5-7 -> 0xFFFFFFFE
    cycle(1'b1, 2'b10, 6'h22, 5, 7, 1'b1);
    check("sub_valid", out_valid, 1'b1);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_ctl", alu_ctl, 4'b0110);
    check("sub_zero", zero, 1'b0);
    idle(1);

    // slt signed
    cycle(1'b1, 2'b10, 6'h2A, 32'hFFFF_FFFF, 1, 1'b1);
    check("slt_neg_result", result, 1);
    check("slt_neg_ctl", alu_ctl, 4'b0111);
    cycle(1'b1, 2'b10, 6'h2A, 1, 32'hFFFF_FFFF, 1'b1);
    check("slt_pos_result", result, 0);
    check("slt_pos_zero", zero, 1'b1);
    idle(1);

    // back-to-back, one result per cycle
    cycle(1'b1, 2'b10, 6'h20, 1, 1, 1'b1);
    check("b2b_add", result, 2);
    cycle(1'b1, 2'b10, 6'h24, 32'hF0, 32'h3C, 1'b1);
    check("b2b_and", result, 32'h30);
    cycle(1'b1, 2'b10, 6'h25, 32'hF0, 32'h0F, 1'b1);
    check("b2b_or", result, 32'hFF);
    cycle(1'b1, 2'b10, 6'h27, 0, 0, 1'b1);
    check("b2b_nor", result, 32'hFFFF_FFFF);
    idle(1);

    // backpressure: new request must wait while output is held
    cycle(1'b1, 2'b00, 6'h00, 10, 20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'b01, 6'h00, 100, 1, 1'b0);
      check("hold_result", result, 30);
      check("hold_in_ready", in_ready, 1'b0);
    end
    cycle(1'b1, 2'b01, 6'h00, 100, 1, 1'b1);
    check("after_hold_result", result, 99);
    idle(1);

    // illegal codes
    cycle(1'b1, 2'b10, 6'h3F, 123, 456, 1'b1);
    check("ill_flag", illegal, 1'b1);
    check("ill_ctl", alu_ctl, 4'hF);
    check("ill_result", result, 0);
    check("ill_zero", zero, 1'b1);
    cycle(1'b1, 2'b11, 6'h20, 1, 2, 1'b1);
    check("op11_flag", illegal, 1'b1);
    idle(1);

`ifdef ALU_EXEC_SHIFT_EN
    // sll 1 by 4: output 5 edges after the request is presented
    cycle(1'b1, 2'b10, 6'h00, 1, 4, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 6'h00, '0, '0, 1'b1);
    check("sll_not_yet", out_valid, 1'b0);
    cycle(1'b0, 2'b00, 6'h00, '0, '0, 1'b1);
    check("sll_valid", out_valid, 1'b1);
    check("sll_result", result, 32'h10);
    idle(1);
    // reset in the middle of a shift discards it
    cycle(1'b1, 2'b10, 6'h02, 32'h8000_0000, 6, 1'b1);
    cycle(1'b0, 2'b00, 6'h00, '0, '0, 1'b1);
    apply_reset();
    idle(2);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [W-1:0] x, y;
      int unsigned sel;
      sel = $urandom_range(0, 11);
      op = 2'b10;
      f = fl[$urandom_range(0, 7)];
      if (sel == 0) op = 2'b00;
      else if (sel == 1) op = 2'b01;
      else if (sel == 2) f = 6'($urandom);
      else if (sel == 3) op = 2'b11;
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: y = x;
        1: begin x = $urandom_range(0, 15); y = $urandom_range(0, 15); end
        default: ;
      endcase
      cycle($urandom_range(0, 3) != 0, op, f, x, y, $urandom_range(0, 2) != 0);
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
